// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// A 16-bit value is captured into a shadow register on Load and promoted to
// the displayed (active) register only at a frame wrap. A frame therefore
// never mixes old and new digits.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero
// digits (digit 0 is always lit).
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Enable     in   1 = scan runs, 0 = scan frozen with all anodes off
//   Load       in   single-cycle strobe capturing ValueIn into the shadow
//   ValueIn    in   [3:0] -> digit 0 (rightmost) ... [15:12] -> digit 3
//   BlankMask  in   bit i forces digit i dark
//   BinOut     out  nibble of the current digit (to hex decoder BinIn)
//   AnodeOut   out  active-low digit enables, at most one bit low
//   DigitIdx   out  current digit slot index
//   FrameTick  out  1-cycle pulse on the 3->0 digit wrap
// ---------------------------------------------------------------------------
module display_scanner #(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Enable,
   input  logic        Load,
   input  logic [15:0] ValueIn,
   input  logic [3:0]  BlankMask,
   output logic [3:0]  BinOut,
   output logic [3:0]  AnodeOut,
   output logic [1:0]  DigitIdx,
   output logic        FrameTick
);

   localparam int unsigned CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

   logic [CntW-1:0] refCnt;
   logic [15:0]     shadow;
   logic [15:0]     active;
   logic            pending;
   logic            slotEnd;
   logic            frameWrap;
   logic            lzb;
   logic            anodeOn;

   assign slotEnd   = Enable && (refCnt == CntMax);
   assign frameWrap = slotEnd && (DigitIdx == 2'd3);

   // Scan counters, frame tick and tear-free shadow -> active promotion
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         refCnt    <= '0;
         DigitIdx  <= 2'd0;
         shadow    <= 16'h0000;
         active    <= 16'h0000;
         pending   <= 1'b0;
         FrameTick <= 1'b0;
      end else begin
         if (!Enable || slotEnd) begin
            refCnt <= '0;
         end else begin
            refCnt <= refCnt + CntW'(1);
         end

         if (slotEnd) begin
            DigitIdx <= DigitIdx + 2'd1;
         end

         FrameTick <= frameWrap;

         // The old shadow is promoted even when a new Load lands on the wrap
         if (frameWrap && pending) begin
            active <= shadow;
         end

         if (Load) begin
            shadow  <= ValueIn;
            pending <= 1'b1;
         end else if (frameWrap) begin
            pending <= 1'b0;
         end
      end
   end

   // Nibble for the current digit, valid even while blanked
   always_comb begin
      BinOut = 4'h0;
      case (DigitIdx)
         2'd0:    BinOut = active[3:0];
         2'd1:    BinOut = active[7:4];
         2'd2:    BinOut = active[11:8];
         default: BinOut = active[15:12];
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit i is a leading zero when nibbles i..3 are all zero
   always_comb begin
      lzb = 1'b0;
      case (DigitIdx)
         2'd0:    lzb = 1'b0;
         2'd1:    lzb = (active[15:4] == 12'h000);
         2'd2:    lzb = (active[15:8] == 8'h00);
         default: lzb = (active[15:12] == 4'h0);
      endcase
   end
`else
   assign lzb = 1'b0;
`endif

   // Anode is lit only after the anti-ghosting window of each slot
   always_comb begin
      anodeOn  = Enable && (refCnt >= BlankEnd) && !BlankMask[DigitIdx] && !lzb;
      AnodeOut = 4'b1111;
      if (anodeOn) begin
         AnodeOut = ~(4'b0001 << DigitIdx);
      end
   end

endmodule
